// File: rtl/multicycle_control_if.sv
// Controller <-> instruction memory / datapath bundle for the multi-cycle control unit.
// master is the control unit; slave is the memory port and datapath it steers.
interface multicycle_control_if;
   logic [31:0] instr;
   logic        mem_ready;
   logic        alu_ovf;
   logic        cond_true;
   logic        mem_req;
   logic        mem_we;
   logic        ir_write;
   logic        pc_write;
   logic        reg_write;
   logic [2:0]  selwsource;
   logic [1:0]  selregdest;
   logic        selimregb;
   logic        selalushift;
   logic [2:0]  aluop;
   logic [1:0]  shiftop;
   logic [1:0]  selpctype;
   logic [2:0]  compop;
   logic        unsig;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [2:0]  state_o;

   modport master (
      input  instr, mem_ready, alu_ovf, cond_true,
      output mem_req, mem_we, ir_write, pc_write, reg_write, selwsource, selregdest,
             selimregb, selalushift, aluop, shiftop, selpctype, compop, unsig,
             trap, trap_cause, state_o
   );

   modport slave (
      output instr, mem_ready, alu_ovf, cond_true,
      input  mem_req, mem_we, ir_write, pc_write, reg_write, selwsource, selregdest,
             selimregb, selalushift, aluop, shiftop, selpctype, compop, unsig,
             trap, trap_cause, state_o
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with memory timeout and trap handling.
// Decoded control fields are latched in DECODE and only driven in the states that use them.
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15,
   parameter bit SHIFT_EN    = 1'b1,
   parameter bit TRAP_ON_OVF = 1'b1
) (
   input logic           clk,
   input logic           rst,
   multicycle_control_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_ILL = 3'd0,
      C_J   = 3'd1,
      C_JR  = 3'd2,
      C_BR  = 3'd3,
      C_ALU = 3'd4,
      C_LW  = 3'd5,
      C_SW  = 3'd6
   } cls_t;

   typedef struct packed {
      cls_t       cls;
      logic [2:0] selwsource;
      logic [1:0] selregdest;
      logic       selimregb;
      logic       selalushift;
      logic [2:0] aluop;
      logic [1:0] shiftop;
      logic [2:0] compop;
      logic       unsig;
      logic       ovf_chk;
   } dec_t;

   localparam logic [1:0] CAUSE_ILL = 2'b01;
   localparam logic [1:0] CAUSE_OVF = 2'b10;
   localparam logic [1:0] CAUSE_TMO = 2'b11;

   localparam bit           TMO_EN = (MEM_TIMEOUT != 0);
   localparam int           CW     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW:0]  LIMIT  = (CW+1)'(MEM_TIMEOUT);

   state_t        state_q, state_d;
   dec_t          dec, d_q;
   logic [5:0]    op_q, fn_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW:0]   cnt_inc;
   logic [1:0]    cause_q, cause_d;
   logic          waiting, tmo_hit, ovf_trap;
   logic          unused_instr_bits;

   assign unused_instr_bits = ^bus.instr[25:6];

   // Opcode/function decode from the latched IR fields.
   always_comb begin
      dec     = '0;
      dec.cls = C_ILL;
      case (op_q)
         6'b000000: begin
            case (fn_q)
               6'b000100: begin dec.cls = C_ALU; dec.selalushift = 1'b1; dec.shiftop = 2'b10; end
               6'b000110: begin dec.cls = C_ALU; dec.selalushift = 1'b1; dec.shiftop = 2'b00; end
               6'b000111: begin dec.cls = C_ALU; dec.selalushift = 1'b1; dec.shiftop = 2'b01; end
               6'b001000: dec.cls = C_JR;
               6'b100000: begin dec.cls = C_ALU; dec.aluop = 3'b010; dec.ovf_chk = 1'b1; end
               6'b100001: begin dec.cls = C_ALU; dec.aluop = 3'b010; dec.unsig = 1'b1; end
               6'b100010: begin dec.cls = C_ALU; dec.aluop = 3'b110; dec.ovf_chk = 1'b1; end
               6'b100011: begin dec.cls = C_ALU; dec.aluop = 3'b110; dec.unsig = 1'b1; end
               6'b100100: begin dec.cls = C_ALU; dec.aluop = 3'b000; end
               6'b100101: begin dec.cls = C_ALU; dec.aluop = 3'b001; end
               6'b100110: begin dec.cls = C_ALU; dec.aluop = 3'b101; end
               6'b100111: begin dec.cls = C_ALU; dec.aluop = 3'b100; end
               default: ;
            endcase
            if (dec.cls == C_ALU) dec.selregdest = 2'b01;
            if (!SHIFT_EN && dec.selalushift) dec = '0;
         end
         6'b000010: dec.cls = C_J;
         6'b000100: begin dec.cls = C_BR; dec.compop = 3'b000; end
         6'b000101: begin dec.cls = C_BR; dec.compop = 3'b101; end
         6'b000110: begin dec.cls = C_BR; dec.compop = 3'b010; end
         6'b000111: begin dec.cls = C_BR; dec.compop = 3'b011; end
         6'b001000: begin dec.cls = C_ALU; dec.selimregb = 1'b1; dec.aluop = 3'b010; dec.ovf_chk = 1'b1; end
         6'b001001: begin dec.cls = C_ALU; dec.selimregb = 1'b1; dec.aluop = 3'b010; dec.unsig = 1'b1; end
         6'b001100: begin dec.cls = C_ALU; dec.selimregb = 1'b1; dec.aluop = 3'b000; end
         6'b001101: begin dec.cls = C_ALU; dec.selimregb = 1'b1; dec.aluop = 3'b001; end
         6'b001110: begin dec.cls = C_ALU; dec.selimregb = 1'b1; dec.aluop = 3'b101; end
         6'b100011: begin
            dec.cls = C_LW; dec.selimregb = 1'b1; dec.aluop = 3'b010; dec.selwsource = 3'b001;
         end
         6'b101011: begin dec.cls = C_SW; dec.selimregb = 1'b1; dec.aluop = 3'b010; end
         default: ;
      endcase
   end

   assign waiting  = (state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready;
   assign cnt_inc  = {1'b0, cnt_q} + (CW+1)'(1);
   assign tmo_hit  = TMO_EN && waiting && (cnt_inc == LIMIT);
   assign ovf_trap = TRAP_ON_OVF && d_q.ovf_chk && bus.alu_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= '0;
         fn_q <= '0;
         d_q  <= '0;
      end else begin
         if (state_q == S_FETCH && bus.mem_ready) begin
            op_q <= bus.instr[31:26];
            fn_q <= bus.instr[5:0];
         end
         if (state_q == S_DECODE) d_q <= dec;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_FETCH: begin
            if (bus.mem_ready)  state_d = S_DECODE;
            else if (tmo_hit) begin state_d = S_TRAP; cause_d = CAUSE_TMO; end
         end
         S_DECODE: begin
            case (dec.cls)
               C_ILL:      begin state_d = S_TRAP; cause_d = CAUSE_ILL; end
               C_J, C_JR:  state_d = S_FETCH;
               default:    state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (d_q.cls)
               C_ALU:      state_d = S_WB;
               C_LW, C_SW: state_d = S_MEM;
               default:    state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (bus.mem_ready)  state_d = (d_q.cls == C_LW) ? S_WB : S_FETCH;
            else if (tmo_hit) begin state_d = S_TRAP; cause_d = CAUSE_TMO; end
         end
         S_WB: begin
            if (ovf_trap) begin state_d = S_TRAP; cause_d = CAUSE_OVF; end
            else          state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // Every state change restarts the wait budget for the next request phase.
      if (state_d != state_q)       cnt_d = '0;
      else if (TMO_EN && waiting)   cnt_d = cnt_inc[CW-1:0];
      else                          cnt_d = cnt_q;
   end

   always_comb begin
      bus.mem_req     = 1'b0;
      bus.mem_we      = 1'b0;
      bus.ir_write    = 1'b0;
      bus.pc_write    = 1'b0;
      bus.reg_write   = 1'b0;
      bus.selwsource  = 3'b000;
      bus.selregdest  = 2'b00;
      bus.selimregb   = 1'b0;
      bus.selalushift = 1'b0;
      bus.aluop       = 3'b000;
      bus.shiftop     = 2'b00;
      bus.selpctype   = 2'b00;
      bus.compop      = 3'b000;
      bus.unsig       = 1'b0;
      bus.trap        = 1'b0;
      bus.trap_cause  = rst ? 2'b00 : cause_q;
      bus.state_o     = rst ? 3'd0 : state_q;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               bus.mem_req = 1'b1;
               if (bus.mem_ready) begin
                  bus.ir_write  = 1'b1;
                  bus.pc_write  = 1'b1;
                  bus.selpctype = 2'b11;
               end
            end
            S_DECODE: begin
               if (dec.cls == C_J) begin
                  bus.pc_write  = 1'b1;
                  bus.selpctype = 2'b10;
               end else if (dec.cls == C_JR) begin
                  bus.pc_write  = 1'b1;
                  bus.selpctype = 2'b01;
               end
            end
            S_EXEC, S_MEM, S_WB: begin
               bus.selwsource  = d_q.selwsource;
               bus.selregdest  = d_q.selregdest;
               bus.selimregb   = d_q.selimregb;
               bus.selalushift = d_q.selalushift;
               bus.aluop       = d_q.aluop;
               bus.shiftop     = d_q.shiftop;
               bus.compop      = d_q.compop;
               bus.unsig       = d_q.unsig;
               if (state_q == S_EXEC && d_q.cls == C_BR) bus.pc_write = bus.cond_true;
               if (state_q == S_MEM) begin
                  bus.mem_req = 1'b1;
                  bus.mem_we  = (d_q.cls == C_SW);
               end
               if (state_q == S_WB) bus.reg_write = !ovf_trap;
            end
            S_TRAP: begin
               bus.trap     = 1'b1;
               bus.pc_write = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle vector bench for multicycle_control: a table of hand-computed
// control bundles plus sequences for timeout, reset-in-MEM and the SHIFT_EN=0 build.
module tb_multicycle_control;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst2 = 1'b1;
   always #5 clk = ~clk;

   multicycle_control_if bus ();
   multicycle_control_if bus2 ();

   multicycle_control #(.MEM_TIMEOUT(15), .SHIFT_EN(1'b1), .TRAP_ON_OVF(1'b1))
      dut (.clk(clk), .rst(rst), .bus(bus));
   multicycle_control #(.MEM_TIMEOUT(15), .SHIFT_EN(1'b0), .TRAP_ON_OVF(1'b1))
      dut2 (.clk(clk), .rst(rst2), .bus(bus2));

   localparam logic [31:0] I_ADD   = 32'h0022_1820;
   localparam logic [31:0] I_LW    = 32'h8C22_0004;
   localparam logic [31:0] I_SW    = 32'hAC22_0004;
   localparam logic [31:0] I_BEQ   = 32'h1022_0003;
   localparam logic [31:0] I_BNE   = 32'h1422_0003;
   localparam logic [31:0] I_ILL   = 32'hFC00_0000;
   localparam logic [31:0] I_ADDI  = 32'h2022_0005;
   localparam logic [31:0] I_ADDIU = 32'h2422_0005;
   localparam logic [31:0] I_J     = 32'h0800_0010;
   localparam logic [31:0] I_JR    = 32'h03E0_0008;
   localparam logic [31:0] I_SRAV  = 32'h0022_1807;
   localparam logic [31:0] I_SLLV  = 32'h0022_1804;

   // {state, mem_req, mem_we, ir_write, pc_write, reg_write, trap, cause,
   //  selwsource, selregdest, selimregb, selalushift, aluop, shiftop, selpctype, compop, unsig}
   logic [28:0] act, act2;
   assign act  = {bus.state_o, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write,
                  bus.reg_write, bus.trap, bus.trap_cause, bus.selwsource, bus.selregdest,
                  bus.selimregb, bus.selalushift, bus.aluop, bus.shiftop, bus.selpctype,
                  bus.compop, bus.unsig};
   assign act2 = {bus2.state_o, bus2.mem_req, bus2.mem_we, bus2.ir_write, bus2.pc_write,
                  bus2.reg_write, bus2.trap, bus2.trap_cause, bus2.selwsource, bus2.selregdest,
                  bus2.selimregb, bus2.selalushift, bus2.aluop, bus2.shiftop, bus2.selpctype,
                  bus2.compop, bus2.unsig};

   typedef struct {
      string       name;
      logic        r;
      logic [31:0] instr;
      logic        rdy, ovf, cond;
      logic [28:0] exp;
   } vec_t;

   vec_t tbl[$];
   int total = 0;
   int bad = 0;

   function automatic logic [28:0] mk(input int st, input int req, input int we, input int irw,
                                      input int pcw, input int rw, input int trp, input int cause,
                                      input int wsrc, input int rdst, input int imm, input int shf,
                                      input int aluop, input int shop, input int pct, input int cmp,
                                      input int uns);
      return {3'(st), 1'(req), 1'(we), 1'(irw), 1'(pcw), 1'(rw), 1'(trp), 2'(cause),
              3'(wsrc), 2'(rdst), 1'(imm), 1'(shf), 3'(aluop), 2'(shop), 2'(pct), 3'(cmp), 1'(uns)};
   endfunction

   function automatic logic [28:0] fe(input int c);
      return mk(0,1,0,1,1,0,0,c, 0,0,0,0,0,0,3,0,0);
   endfunction

   function automatic logic [28:0] de(input int c);
      return mk(1,0,0,0,0,0,0,c, 0,0,0,0,0,0,0,0,0);
   endfunction

   function automatic void add(input string n, input int r, input logic [31:0] i, input int rdy,
                               input int ovf, input int cond, input logic [28:0] e);
      vec_t v;
      v.name = n; v.r = 1'(r); v.instr = i; v.rdy = 1'(rdy); v.ovf = 1'(ovf); v.cond = 1'(cond);
      v.exp = e;
      tbl.push_back(v);
   endfunction

   task automatic check(input string n, input logic [28:0] a, input logic [28:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   task automatic step(input string n, input int r, input logic [31:0] i, input int rdy,
                       input int ovf, input int cond, input logic [28:0] e);
      rst = 1'(r);
      bus.instr = i; bus.mem_ready = 1'(rdy); bus.alu_ovf = 1'(ovf); bus.cond_true = 1'(cond);
      @(negedge clk);
      check(n, act, e);
      @(posedge clk);
      #1;
   endtask

   task automatic step2(input string n, input logic [31:0] i, input int rdy, input logic [28:0] e);
      bus2.instr = i; bus2.mem_ready = 1'(rdy);
      @(negedge clk);
      check(n, act2, e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.instr = '0; bus.mem_ready = 1'b0; bus.alu_ovf = 1'b0; bus.cond_true = 1'b0;
      bus2.instr = '0; bus2.mem_ready = 1'b0; bus2.alu_ovf = 1'b0; bus2.cond_true = 1'b0;

      add("reset",   1, I_ADD, 1,0,0, '0);
      add("add_f",   0, I_ADD, 1,0,0, fe(0));
      add("add_d",   0, I_ADD, 1,0,0, de(0));
      add("add_e",   0, I_ADD, 1,0,0, mk(2,0,0,0,0,0,0,0, 0,1,0,0,2,0,0,0,0));
      add("add_w",   0, I_ADD, 1,0,0, mk(4,0,0,0,0,1,0,0, 0,1,0,0,2,0,0,0,0));
      add("lw_f",    0, I_LW,  1,0,0, fe(0));
      add("lw_d",    0, I_LW,  1,0,0, de(0));
      add("lw_e",    0, I_LW,  1,0,0, mk(2,0,0,0,0,0,0,0, 1,0,1,0,2,0,0,0,0));
      add("lw_m0",   0, I_LW,  0,0,0, mk(3,1,0,0,0,0,0,0, 1,0,1,0,2,0,0,0,0));
      add("lw_m1",   0, I_LW,  0,0,0, mk(3,1,0,0,0,0,0,0, 1,0,1,0,2,0,0,0,0));
      add("lw_m2",   0, I_LW,  0,0,0, mk(3,1,0,0,0,0,0,0, 1,0,1,0,2,0,0,0,0));
      add("lw_m3",   0, I_LW,  1,0,0, mk(3,1,0,0,0,0,0,0, 1,0,1,0,2,0,0,0,0));
      add("lw_w",    0, I_LW,  1,0,0, mk(4,0,0,0,0,1,0,0, 1,0,1,0,2,0,0,0,0));
      add("beq0_f",  0, I_BEQ, 1,0,0, fe(0));
      add("beq0_d",  0, I_BEQ, 1,0,0, de(0));
      add("beq0_e",  0, I_BEQ, 1,0,0, mk(2,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
      add("beq1_f",  0, I_BEQ, 1,0,1, fe(0));
      add("beq1_d",  0, I_BEQ, 1,0,1, de(0));
      add("beq1_e",  0, I_BEQ, 1,0,1, mk(2,0,0,0,1,0,0,0, 0,0,0,0,0,0,0,0,0));
      add("ill_f",   0, I_ILL, 1,0,0, fe(0));
      add("ill_d",   0, I_ILL, 1,0,0, de(0));
      add("ill_t",   0, I_ILL, 1,0,0, mk(5,0,0,0,1,0,1,1, 0,0,0,0,0,0,0,0,0));
      add("addi_f",  0, I_ADDI, 1,0,0, fe(1));
      add("addi_d",  0, I_ADDI, 1,0,0, de(1));
      add("addi_e",  0, I_ADDI, 1,0,0, mk(2,0,0,0,0,0,0,1, 0,0,1,0,2,0,0,0,0));
      add("addi_w",  0, I_ADDI, 1,1,0, mk(4,0,0,0,0,0,0,1, 0,0,1,0,2,0,0,0,0));
      add("addi_t",  0, I_ADDI, 1,0,0, mk(5,0,0,0,1,0,1,2, 0,0,0,0,0,0,0,0,0));
      add("addiu_f", 0, I_ADDIU, 1,0,0, fe(2));
      add("addiu_d", 0, I_ADDIU, 1,0,0, de(2));
      add("addiu_e", 0, I_ADDIU, 1,0,0, mk(2,0,0,0,0,0,0,2, 0,0,1,0,2,0,0,0,1));
      add("addiu_w", 0, I_ADDIU, 1,1,0, mk(4,0,0,0,0,1,0,2, 0,0,1,0,2,0,0,0,1));
      add("j_f",     0, I_J,   1,0,0, fe(2));
      add("j_d",     0, I_J,   1,0,0, mk(1,0,0,0,1,0,0,2, 0,0,0,0,0,0,2,0,0));
      add("sw_f",    0, I_SW,  1,0,0, fe(2));
      add("sw_d",    0, I_SW,  1,0,0, de(2));
      add("sw_e",    0, I_SW,  1,0,0, mk(2,0,0,0,0,0,0,2, 0,0,1,0,2,0,0,0,0));
      add("sw_m",    0, I_SW,  1,0,0, mk(3,1,1,0,0,0,0,2, 0,0,1,0,2,0,0,0,0));
      add("jr_f",    0, I_JR,  1,0,0, fe(2));
      add("jr_d",    0, I_JR,  1,0,0, mk(1,0,0,0,1,0,0,2, 0,0,0,0,0,0,1,0,0));
      add("bne_f",   0, I_BNE, 1,0,1, fe(2));
      add("bne_d",   0, I_BNE, 1,0,1, de(2));
      add("bne_e",   0, I_BNE, 1,0,1, mk(2,0,0,0,1,0,0,2, 0,0,0,0,0,0,0,5,0));
      add("srav_f",  0, I_SRAV, 1,0,0, fe(2));
      add("srav_d",  0, I_SRAV, 1,0,0, de(2));
      add("srav_e",  0, I_SRAV, 1,0,0, mk(2,0,0,0,0,0,0,2, 0,1,0,1,0,1,0,0,0));
      add("srav_w",  0, I_SRAV, 1,0,0, mk(4,0,0,0,0,1,0,2, 0,1,0,1,0,1,0,0,0));

      repeat (2) @(posedge clk);
      #1;
      foreach (tbl[k]) step($sformatf("%s[%0d]", tbl[k].name, k), int'(tbl[k].r), tbl[k].instr,
                            int'(tbl[k].rdy), int'(tbl[k].ovf), int'(tbl[k].cond), tbl[k].exp);

      // FETCH never answered: 15 request cycles, then a bus-timeout trap
      for (int k = 0; k < 15; k++)
         step($sformatf("tmo_wait[%0d]", k), 0, I_ADD, 0,0,0, mk(0,1,0,0,0,0,0,2, 0,0,0,0,0,0,0,0,0));
      step("tmo_trap", 0, I_ADD, 0,0,0, mk(5,0,0,0,1,0,1,3, 0,0,0,0,0,0,0,0,0));

      // ready arriving on the limit cycle wins over the timeout
      for (int k = 0; k < 14; k++)
         step($sformatf("edge_wait[%0d]", k), 0, I_LW, 0,0,0, mk(0,1,0,0,0,0,0,3, 0,0,0,0,0,0,0,0,0));
      step("edge_rdy",  0, I_LW, 1,0,0, fe(3));
      step("edge_dec",  0, I_LW, 1,0,0, de(3));
      step("edge_exec", 0, I_LW, 1,0,0, mk(2,0,0,0,0,0,0,3, 1,0,1,0,2,0,0,0,0));
      step("mem_wait0", 0, I_LW, 0,0,0, mk(3,1,0,0,0,0,0,3, 1,0,1,0,2,0,0,0,0));
      step("mem_wait1", 0, I_LW, 0,0,0, mk(3,1,0,0,0,0,0,3, 1,0,1,0,2,0,0,0,0));
      step("rst_mid_mem", 1, I_LW, 1,1,1, '0);
      step("post_rst_fetch", 0, I_LW, 0,0,0, mk(0,1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));

      // SHIFT_EN=0 build: SLLV is illegal
      rst2 = 1'b0;
      step2("s0_sllv_f", I_SLLV, 1, fe(0));
      step2("s0_sllv_d", I_SLLV, 1, de(0));
      step2("s0_sllv_t", I_SLLV, 1, mk(5,0,0,0,1,0,1,1, 0,0,0,0,0,0,0,0,0));
      step2("s0_after",  I_SLLV, 0, mk(0,1,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
